spi_slave_regfile: RTL and testbench

//  SPI mode-0 responder (slave) holding a small byte-addressed register file.
//  It is the far end of the master's ss/sclk/mosi/miso link and models an

---
 rtl/spi_slave_regfile.sv | 216 +++++++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 responder with a byte-addressed register file.
// The SPI pins are oversampled in the system clock domain. Frames have the
// form CMD, ADDR, then data bytes. Writes are reported back to the host as
// one-cycle strobes, and reads stream the file out on miso with the address
// auto-incrementing.
module spi_slave_regfile #(
    parameter int unsigned ADDR_W      = 6,
    parameter logic [7:0]  CMD_WR      = 8'h0A,
    parameter logic [7:0]  CMD_RD      = 8'h0B,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic              hw_we,
    input  logic [ADDR_W-1:0] hw_addr,
    input  logic [7:0]        hw_wdata,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_IGNORE
    } state_t;

    // Synchroniser chains and the previous synchronised values used for edge detection.
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   ss_prev_q;

    // Transaction state.
    state_t            state_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        shift_in_q;
    logic [7:0]        shift_out_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              rd_q;
    logic              miso_q;
    logic              miso_oe_q;
    logic              busy_q;
    logic              wr_strobe_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;

    logic [7:0] regs_q [DEPTH];

    // Synchronised copies and the events derived from them.
    logic              sclk_s, ss_s, mosi_s;
    logic              sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic              shifting, byte_done, spi_we;
    logic [7:0]        rx_byte;
    logic [ADDR_W-1:0] addr_in;
    logic [ADDR_W-1:0] ptr_next;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_rise   = ss_s & ~ss_prev_q;
    assign ss_fall   = ~ss_s & ss_prev_q;

    // mosi is shifted in on every rise while a frame is decoding bytes.
    assign shifting  = sclk_rise && (state_q inside {S_CMD, S_ADDR, S_WDATA, S_RDATA});
    // A deselect in the same cycle as the 8th rise still counts as an abort.
    assign byte_done = shifting && (bit_cnt_q == 3'd7) && !ss_rise;
    assign rx_byte   = {shift_in_q[6:0], mosi_s};
    assign addr_in   = rx_byte[ADDR_W-1:0];
    assign ptr_next  = ptr_q + ADDR_W'(1);
    assign spi_we    = byte_done && (state_q == S_WDATA);

    // Bring sclk, ss and mosi into the clk domain and remember the last synchronised value.
    // NOTE: every sequential block uses non-blocking assignments, so all flops see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
        end
    end

    // Register file: the host can write at any time, and an SPI commit to the same address wins.
    // NOTE: the file must read back as zero after reset, so it is built from resettable flops, not RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (hw_we) begin
                regs_q[hw_addr] <= hw_wdata;
            end
            // The later assignment takes precedence on an address collision.
            if (spi_we) begin
                regs_q[ptr_q] <= rx_byte;
            end
        end
    end

    // Frame decoder: byte assembly, command/address handling, read shifting and write strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            ptr_q       <= '0;
            rd_q        <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            busy_q      <= ~ss_s;
            miso_oe_q   <= ~ss_s;

            if (ss_rise) begin
                // Deselect aborts whatever is in flight; a partial byte is dropped.
                state_q   <= S_IDLE;
                bit_cnt_q <= '0;
                miso_q    <= 1'b0;
            end else begin
                if (shifting) begin
                    shift_in_q <= rx_byte;
                    bit_cnt_q  <= bit_cnt_q + 3'd1;
                end

                unique case (state_q)
                    S_IDLE: begin
                        if (ss_fall) begin
                            state_q   <= S_CMD;
                            bit_cnt_q <= '0;
                        end
                    end
                    S_CMD: begin
                        if (byte_done) begin
                            rd_q    <= (rx_byte == CMD_RD);
                            state_q <= (rx_byte == CMD_WR || rx_byte == CMD_RD) ? S_ADDR : S_IGNORE;
                        end
                    end
                    S_ADDR: begin
                        if (byte_done) begin
                            ptr_q <= addr_in;
                            if (rd_q) begin
                                state_q     <= S_RDATA;
                                shift_out_q <= regs_q[addr_in];
                            end else begin
                                state_q <= S_WDATA;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (byte_done) begin
                            wr_strobe_q <= 1'b1;
                            wr_addr_q   <= ptr_q;
                            wr_data_q   <= rx_byte;
                            ptr_q       <= ptr_next;
                        end
                    end
                    S_RDATA: begin
                        // A fall and a rise never share a cycle, so these two updates cannot collide.
                        if (sclk_fall) begin
                            miso_q      <= shift_out_q[7];
                            shift_out_q <= {shift_out_q[6:0], 1'b0};
                        end
                        if (byte_done) begin
                            ptr_q       <= ptr_next;
                            shift_out_q <= regs_q[ptr_next];
                        end
                    end
                    S_IGNORE: begin
                        // Wait for deselect; miso stays low.
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign miso      = miso_q;
    assign miso_oe   = miso_oe_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile. An SPI master drives frames built from directed
// and random transactions. A flat byte-array reference model predicts the write
// strobes and the miso bytes, and queues carry those predictions to a monitor
// that checks them against what the DUT presents.
`timescale 1ns/1ps
module tb_spi_slave_regfile;

    localparam int         ADDR_W = 6;
    localparam int         DEPTH  = 64;
    localparam int         T_HALF = 50;      // sclk half period: 5 clk cycles
    localparam logic [7:0] CMD_WR = 8'h0A;
    localparam logic [7:0] CMD_RD = 8'h0B;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sclk = 1'b0;
    logic              ss = 1'b1;
    logic              mosi = 1'b0;
    logic              miso, miso_oe;
    logic              hw_we = 1'b0;
    logic [ADDR_W-1:0] hw_addr = '0;
    logic [7:0]        hw_wdata = '0;
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;

    always #5 clk = ~clk;

    spi_slave_regfile #(
        .ADDR_W(ADDR_W), .CMD_WR(CMD_WR), .CMD_RD(CMD_RD), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .hw_we(hw_we), .hw_addr(hw_addr), .hw_wdata(hw_wdata),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_evt_t;

    int          pass_cnt = 0;
    int          check_cnt = 0;
    int          spurious_cnt = 0;
    logic [7:0]  model   [DEPTH];
    logic [7:0]  tx_buf  [80];
    logic [7:0]  rx_buf  [80];
    logic [7:0]  payload [80];
    wr_evt_t     exp_wr_q [$];
    logic [7:0]  exp_rd_q [$];
    logic [7:0]  act_rd_q [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Monitor: compares every DUT write strobe and every captured miso byte with the predictions.
    always @(negedge clk) begin : monitor
        wr_evt_t    ev;
        logic [7:0] got;
        if (wr_strobe) begin
            if (exp_wr_q.size() == 0) begin
                spurious_cnt++;
            end else begin
                ev = exp_wr_q.pop_front();
                check("wr_strobe_addr", 32'(wr_addr), 32'(ev.addr));
                check("wr_strobe_data", 32'(wr_data), 32'(ev.data));
            end
        end
        while (act_rd_q.size() > 0) begin
            got = act_rd_q.pop_front();
            if (exp_rd_q.size() == 0) begin
                spurious_cnt++;
            end else begin
                check("miso_byte", 32'(got), 32'(exp_rd_q.pop_front()));
            end
        end
    end

    // Watchdog so the bench always terminates.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Shift nbits out of tx_buf MSB first. miso is captured just before each rise.
    task automatic spi_xfer(input int nbits, input bit leave_ss_low);
        for (int i = 0; i < 80; i++) rx_buf[i] = 8'h00;
        @(negedge clk);
        ss = 1'b0;
        #(2 * T_HALF);
        for (int i = 0; i < nbits; i++) begin
            mosi = tx_buf[i / 8][7 - (i % 8)];
            #(T_HALF);
            rx_buf[i / 8][7 - (i % 8)] = miso;
            if (i == 0) begin
                check("miso_oe_in_frame", 32'(miso_oe), 32'd1);
                check("busy_in_frame", 32'(busy), 32'd1);
            end
            sclk = 1'b1;
            #(T_HALF);
            sclk = 1'b0;
        end
        mosi = 1'b0;
        #(T_HALF);
        if (!leave_ss_low) begin
            ss = 1'b1;
            #(4 * T_HALF);
            check("miso_oe_idle", 32'(miso_oe), 32'd0);
            check("busy_idle", 32'(busy), 32'd0);
        end
    endtask

    task automatic push_rx(input int nbytes);
        for (int i = 0; i < nbytes; i++) act_rd_q.push_back(rx_buf[i]);
    endtask

    task automatic hw_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        @(negedge clk);
        hw_we = 1'b1;
        hw_addr = a;
        hw_wdata = d;
        @(negedge clk);
        hw_we = 1'b0;
        model[a] = d;
    endtask

    // Write payload[0..n-1] starting at a. The unused upper address bits are randomised.
    task automatic spi_write(input logic [ADDR_W-1:0] a, input int n);
        logic [1:0]        up;
        logic [ADDR_W-1:0] idx;
        wr_evt_t           ev;
        up = 2'($urandom);
        tx_buf[0] = CMD_WR;
        tx_buf[1] = {up, a};
        for (int i = 0; i < n; i++) begin
            tx_buf[2 + i] = payload[i];
            idx = ADDR_W'((int'(a) + i) % DEPTH);
            model[idx] = payload[i];
            ev.addr = idx;
            ev.data = payload[i];
            exp_wr_q.push_back(ev);
        end
        for (int i = 0; i < n + 2; i++) exp_rd_q.push_back(8'h00);
        spi_xfer((n + 2) * 8, 1'b0);
        push_rx(n + 2);
    endtask

    // Read n bytes from a. The command and address bytes must see miso low.
    task automatic spi_read(input logic [ADDR_W-1:0] a, input int n);
        logic [1:0] up;
        up = 2'($urandom);
        tx_buf[0] = CMD_RD;
        tx_buf[1] = {up, a};
        exp_rd_q.push_back(8'h00);
        exp_rd_q.push_back(8'h00);
        for (int i = 0; i < n; i++) begin
            tx_buf[2 + i] = 8'($urandom);
            exp_rd_q.push_back(model[(int'(a) + i) % DEPTH]);
        end
        spi_xfer((n + 2) * 8, 1'b0);
        push_rx(n + 2);
    endtask

    // Frame with an unknown command: no writes, miso low for every byte.
    task automatic spi_bad(input logic [7:0] cmd, input int nbytes);
        tx_buf[0] = cmd;
        for (int i = 1; i < nbytes; i++) tx_buf[i] = 8'($urandom);
        for (int i = 0; i < nbytes; i++) exp_rd_q.push_back(8'h00);
        spi_xfer(nbytes * 8, 1'b0);
        push_rx(nbytes);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;

        // Reset state, sampled while reset is still asserted.
        #1;
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_miso_oe", 32'(miso_oe), 32'd0);
        check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);

        // 1: single write, then read it back.
        payload[0] = 8'h5A;
        spi_write(6'h1F, 1);
        spi_read(6'h1F, 1);

        // 2: host load, then SPI read. The MSB is sampled before the first data rise.
        hw_write(6'h08, 8'hC3);
        spi_read(6'h08, 1);

        // 3: burst write across the top of the address space.
        payload[0] = 8'h11;
        payload[1] = 8'h22;
        spi_write(6'h3F, 2);
        spi_read(6'h3F, 2);

        // 4: bad command, then confirm that reg[3F] is untouched.
        tx_buf[1] = 8'h3F;
        tx_buf[0] = 8'h55;
        tx_buf[2] = 8'hAA;
        for (int i = 0; i < 3; i++) exp_rd_q.push_back(8'h00);
        spi_xfer(24, 1'b0);
        push_rx(3);
        spi_read(6'h3F, 1);

        // 5: abort after 4 bits of a data byte, then check the next frame.
        hw_write(6'h10, 8'h77);
        tx_buf[0] = CMD_WR;
        tx_buf[1] = 8'h10;
        tx_buf[2] = 8'hAB;
        for (int i = 0; i < 3; i++) exp_rd_q.push_back(8'h00);
        spi_xfer(20, 1'b0);
        push_rx(3);
        spi_read(6'h10, 1);

        // Random mix of writes, reads, host loads and bad commands.
        for (int k = 0; k < 24; k++) begin
            int                kind;
            int                n;
            logic [ADDR_W-1:0] a;
            logic [7:0]        c;
            kind = int'($urandom_range(0, 3));
            n    = int'($urandom_range(1, 4));
            a    = ADDR_W'($urandom);
            case (kind)
                0: begin
                    for (int i = 0; i < n; i++) payload[i] = 8'($urandom);
                    spi_write(a, n);
                end
                1: spi_read(a, n);
                2: begin
                    hw_write(a, 8'($urandom));
                    spi_read(a, 1);
                end
                default: begin
                    do c = 8'($urandom); while (c == CMD_WR || c == CMD_RD);
                    spi_bad(c, n + 2);
                end
            endcase
        end

        // 6: reset in the middle of a read data byte of 0xFF.
        hw_write(6'h20, 8'hFF);
        tx_buf[0] = CMD_RD;
        tx_buf[1] = 8'h20;
        tx_buf[2] = 8'h00;
        spi_xfer(19, 1'b1);
        check("miso_before_reset", 32'(miso), 32'd1);
        rst = 1'b1;
        #1;
        check("midread_rst_miso", 32'(miso), 32'd0);
        check("midread_rst_miso_oe", 32'(miso_oe), 32'd0);
        check("midread_rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
        ss = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        spi_read(6'h00, DEPTH);

        // Let the monitor drain, then make sure nothing is left over or unexpected.
        repeat (20) @(negedge clk);
        check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
        check("spurious_events", 32'(spurious_cnt), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
